// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard decoder: scan codes,
// decode FSM states and key indices.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_EUP    = 8'h75;
  localparam logic [7:0] SC_EDOWN  = 8'h72;
  localparam logic [7:0] SC_ELEFT  = 8'h6B;
  localparam logic [7:0] SC_ERIGHT = 8'h74;
  localparam logic [7:0] SC_UP     = 8'h1D;
  localparam logic [7:0] SC_DOWN   = 8'h1B;
  localparam logic [7:0] SC_LEFT   = 8'h1C;
  localparam logic [7:0] SC_RIGHT  = 8'h23;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ENTER = 4;
  localparam int NKEYS     = 5;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  // One-hot key mask for a code seen after an optional E0 prefix.
  function automatic logic [NKEYS-1:0] key_mask(
    input logic       ext,
    input logic [7:0] c
  );
    logic [NKEYS-1:0] m;
    m = '0;
    unique case (1'b1)
      (ext && c == SC_EUP) || (!ext && c == SC_UP):
        m[KEY_UP] = 1'b1;
      (ext && c == SC_EDOWN) || (!ext && c == SC_DOWN):
        m[KEY_DOWN] = 1'b1;
      (ext && c == SC_ELEFT) || (!ext && c == SC_LEFT):
        m[KEY_LEFT] = 1'b1;
      (ext && c == SC_ERIGHT) || (!ext && c == SC_RIGHT):
        m[KEY_RIGHT] = 1'b1;
      (!ext && c == SC_ENTER):
        m[KEY_ENTER] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 bit-level receiver: sync, clock glitch filter, framing, timeout.
// Parity is checked only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500,
  parameter int FILT_LEN       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    csync;
  logic [1:0]    dsync;
  logic          c_s;
  logic          d_s;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic [3:0]    bcnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;
  logic          parity_ok;

  assign c_s = csync[1];
  assign d_s = dsync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csync <= '0;
      dsync <= '0;
    end else begin
      csync <= {csync[0], ps2_clk};
      dsync <= {dsync[0], ps2_data};
    end
  end

  // Filtered level flips after FILT_LEN consecutive differing samples.
  assign fall = filt && !c_s && (fcnt == FW'(FILT_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (c_s == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT_LEN - 1)) begin
      filt <= c_s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (fall && bcnt == 4'd9) begin
      par <= d_s;
    end
  end

  assign parity_ok = ^{shreg, par};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt       <= '0;
      shreg      <= '0;
      tcnt       <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (bcnt)
          4'd0: if (!d_s) bcnt <= 4'd1;
          4'd10: begin
            bcnt <= '0;
            if (d_s && parity_ok) begin
              code       <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            if (bcnt <= 4'd8) shreg <= {d_s, shreg[7:1]};
            bcnt <= bcnt + 4'd1;
          end
        endcase
      end else if (bcnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tcnt      <= '0;
          bcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to game-key decoder: E0/F0 prefix FSM, held-key
// suppression of typematic repeats. Optional PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500,
  parameter int FILT_LEN       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_enter,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  dec_state_t       state;
  dec_state_t       state_n;
  logic [NKEYS-1:0] held;
  logic [NKEYS-1:0] held_n;
  logic [NKEYS-1:0] pulse_n;
  logic [NKEYS-1:0] mk_idle;
  logic [NKEYS-1:0] mk_ext;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILT_LEN      (FILT_LEN)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  assign mk_idle = key_mask(1'b0, code);
  assign mk_ext  = key_mask(1'b1, code);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      held  <= '0;
    end else begin
      state <= state_n;
      held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    held_n  = held;
    pulse_n = '0;
    if (frame_err) begin
      state_n = IDLE;
    end else if (code_valid) begin
      unique case (state)
        IDLE: begin
          if (code == SC_E0) begin
            state_n = EXT;
          end else if (code == SC_F0) begin
            state_n = BRK;
          end else begin
            pulse_n = mk_idle & ~held;
            held_n  = held | mk_idle;
            state_n = IDLE;
          end
        end
        EXT: begin
          if (code == SC_E0) begin
            state_n = EXT;
          end else if (code == SC_F0) begin
            state_n = EXT_BRK;
          end else begin
            pulse_n = mk_ext & ~held;
            held_n  = held | mk_ext;
            state_n = IDLE;
          end
        end
        BRK: begin
          held_n  = held & ~mk_idle;
          state_n = IDLE;
        end
        EXT_BRK: begin
          held_n  = held & ~mk_ext;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_up    <= 1'b0;
      key_down  <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_enter <= 1'b0;
    end else begin
      key_up    <= pulse_n[KEY_UP];
      key_down  <= pulse_n[KEY_DOWN];
      key_left  <= pulse_n[KEY_LEFT];
      key_right <= pulse_n[KEY_RIGHT];
      key_enter <= pulse_n[KEY_ENTER];
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed scoreboard bench for ps2_key_decoder.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_enter;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] sb[$];
  logic [15:0] obs;
  logic [15:0] exp_ev;
  logic [4:0]  keys;
  logic        cv_prev = 1'b0;

  ps2_key_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .key_enter (key_enter),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Key masks: {enter, right, left, down, up}
  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_DOWN  = 5'b00010;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_ENTER = 5'b10000;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_edges(input logic [7:0] b, input int n,
                            input logic flip, input logic stop);
    logic [10:0] bits;
    bits = {stop, ~^b ^ flip, b, 1'b0};
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask

  task automatic send(input logic [7:0] b);
    send_edges(b, 11, 1'b0, 1'b1);
    tick(100);
  endtask

  task automatic exp_cv(input logic [7:0] c);
    sb.push_back({3'b010, 5'b0, c});
  endtask

  task automatic exp_key(input logic [4:0] k);
    sb.push_back({3'b000, k, 8'h00});
  endtask

  task automatic exp_fe();
    sb.push_back({3'b001, 5'b0, 8'h00});
  endtask

  task automatic drain(input string tag);
    tick(50);
    vectors++;
    assert (sb.size() === 0) else begin
      miscompares++;
      $error("FAIL %s: outstanding=%0d required=0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    assert ({key_up, key_down, key_left, key_right, key_enter,
             code, code_valid, frame_err} === 15'h0) else begin
      miscompares++;
      $error("FAIL %s: outputs=%h code=%h required all 0", tag,
             {key_up, key_down, key_left, key_right, key_enter,
              code_valid, frame_err}, code);
    end
  endtask

  always @(negedge clk) begin
    keys = {key_enter, key_right, key_left, key_down, key_up};
    obs  = {1'b0, code_valid, frame_err, keys,
            code_valid ? code : 8'h00};
    if (obs !== 16'h0) begin
      vectors++;
      exp_ev = (sb.size() == 0) ? 16'hFFFF : sb.pop_front();
      assert (obs === exp_ev) else begin
        miscompares++;
        $error("FAIL event: observed=%h expected=%h", obs, exp_ev);
      end
    end
    if (keys !== 5'b0) begin
      vectors++;
      assert (cv_prev === 1'b1) else begin
        miscompares++;
        $error("FAIL key_timing: prev code_valid=%b required 1", cv_prev);
      end
    end
    cv_prev = code_valid;
  end

  initial begin
    #5ms;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    tick(20);

    exp_cv(8'hE0); exp_cv(8'h75); exp_key(K_UP);
    send(8'hE0); send(8'h75);
    drain("e0_75_up");

    exp_cv(8'h11);
    send(8'h11);
    drain("unknown_code");

    exp_cv(8'hE0); exp_cv(8'hE0); exp_cv(8'h72); exp_key(K_DOWN);
    send(8'hE0); send(8'hE0); send(8'h72);
    drain("e0_e0_down");

    exp_cv(8'h5A); exp_key(K_ENTER);
    exp_cv(8'h5A); exp_cv(8'h5A); exp_cv(8'hF0);
    exp_cv(8'h5A); exp_cv(8'h5A); exp_key(K_ENTER);
    send(8'h5A); send(8'h5A); send(8'h5A);
    send(8'hF0); send(8'h5A); send(8'h5A);
    drain("enter_typematic");

    exp_fe();
    send_edges(8'h1D, 11, 1'b0, 1'b0);
    tick(100);
    exp_cv(8'hE0); exp_cv(8'h6B); exp_key(K_LEFT);
    send(8'hE0); send(8'h6B);
    drain("stop_err_then_left");

    exp_cv(8'hE0); exp_cv(8'hF0); exp_cv(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B);
    drain("left_ext_break");

    exp_fe();
    send_edges(8'h1C, 5, 1'b0, 1'b1);
    tick(3000);
    exp_cv(8'h1C); exp_key(K_LEFT);
    send(8'h1C);
    drain("timeout_then_left");

    exp_cv(8'hE0); exp_cv(8'hF0); exp_cv(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain("up_break");

`ifdef PS2_PARITY_CHECK_EN
    exp_fe();
`else
    exp_cv(8'h1D); exp_key(K_UP);
`endif
    send_edges(8'h1D, 11, 1'b1, 1'b1);
    tick(100);
    drain("bad_parity_1d");

    send_edges(8'h5A, 6, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    tick(3);
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    exp_cv(8'h5A); exp_key(K_ENTER);
    send(8'h5A);
    drain("enter_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500, giving the idle clk cycles mid-frame before the frame is abandoned (100 us at 25 MHz).
REQ-002 SHALL have parameter FILT_LEN, default 4, giving the number of consecutive equal synchronized samples required to accept a ps2_clk level change.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, 25 MHz domain.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: keyboard data, asynchronous to clk.
REQ-007 SHALL have ports key_up, key_down, key_left and key_right, each output, 1 bit: one-cycle direction pulses.
REQ-008 SHALL have port key_enter, output, 1 bit: one-cycle place pulse.
REQ-009 SHALL have port code, output, 8 bits: last received byte.
REQ-010 SHALL have port code_valid, output, 1 bit: one-cycle pulse when code updates.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a rejected frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers, then a FILT_LEN glitch filter on ps2_clk.
REQ-013 SHALL act only on a filtered ps2_clk falling edge and SHALL sample synchronized ps2_data in that cycle.
REQ-014 SHALL receive frames as: start 0, 8 data bits LSB first, odd parity, stop 1 (11 edges).
REQ-015 SHALL ignore a start sample of 1 and keep waiting for a start bit.
REQ-016 SHALL, on a stop sample of 0, discard the byte and pulse frame_err.
REQ-017 SHALL, when no falling edge arrives for TIMEOUT_CYCLES while the bit count is between 1 and 10, reset the bit count and pulse frame_err.
REQ-018 SHALL, on a good frame, assert code and code_valid in the cycle after the 11th edge.
REQ-019 SHALL use decode FSM states IDLE, EXT, BRK and EXT_BRK.
REQ-020 SHALL make these FSM transitions: E0 takes IDLE to EXT; F0 takes IDLE to BRK; F0 takes EXT to EXT_BRK; any other byte returns to IDLE.
REQ-021 SHALL map make codes as: EXT+75 or IDLE+1D to up; EXT+72 or IDLE+1B to down; EXT+6B or IDLE+1C to left; EXT+74 or IDLE+23 to right; IDLE+5A to enter.
REQ-022 SHALL assert a key pulse exactly 1 cycle after the code_valid that completes the make sequence.
REQ-023 SHALL emit at most one key pulse per cycle.
REQ-024 SHALL keep a per-key held bit: a make sets it and emits a pulse only if it was clear, so typematic repeats are suppressed.
REQ-025 SHALL clear the held bit on the matching break sequence (BRK/EXT_BRK followed by the code) and SHALL emit no pulse for the break.
REQ-026 SHALL, for unknown codes, pulse code_valid, emit no key pulse and return to IDLE.
REQ-027 SHALL, for E0 followed by E0, remain in EXT.
REQ-028 SHALL reset the decode FSM to IDLE and leave held bits unchanged on frame_err.

Reset
REQ-029 SHALL, on rst assertion, immediately clear all outputs, code, the bit count, shift register, timeout counter, held bits and filter, and set the FSM to IDLE.
REQ-030 SHALL, when rst is asserted mid-frame, discard the partial frame; the first frame after release is received normally.

Configuration
REQ-031 SHALL, when PS2_PARITY_CHECK_EN is defined, discard frames with even parity over data plus parity bit and pulse frame_err.
REQ-032 SHALL, when PS2_PARITY_CHECK_EN is undefined, ignore the parity bit entirely.

Structure
REQ-033 SHALL place the scan-code constants (E0, F0, 75, 72, 6B, 74, 1D, 1B, 1C, 23, 5A), the FSM state encoding and the key index constants in package ps2_pkg.
REQ-034 SHALL implement the bit-level receiver (sync, filter, shift, parity, timeout) as sub-module ps2_frame_rx; the decode FSM and held bits live in the top module.

Verification
REQ-035 SHALL verify: frames E0,75 -> one key_up pulse 1 cycle after the second code_valid; code=75.
REQ-036 SHALL verify: 5A,5A,5A,F0,5A,5A -> exactly two key_enter pulses (first make, then make after break).
REQ-037 SHALL verify: a frame with stop bit 0 -> frame_err pulse, no code_valid; next E0,6B -> key_left.
REQ-038 SHALL verify: 5 edges then 3000 idle cycles -> frame_err once; a following 1C frame -> key_left.
REQ-039 SHALL verify: a data byte 1D with flipped parity -> frame_err and no key_up with PS2_PARITY_CHECK_EN; key_up without it.
REQ-040 SHALL verify: rst asserted after 6 edges of a 5A frame -> all outputs 0 at once; a clean 5A after release -> key_enter.
